rv_dmem_arbiter: RTL
====================

RV_DMEM_ARBITER -- requirements
Module: rv_dmem_arbiter

Interface
REQ-001 Parameter: STARVE_LIMIT, default 3, max consecutive cycles the external requester waits before a forced grant (range 1..15).
REQ-002 One clock; reset is synchronous and active-high.
REQ-003 i_arb_clk  in  1  clock; all state changes on rising edge.
REQ-004 i_arb_rst  in  1  reset; synchronous, active-high.
REQ-005 i_arb_core_req  in  1  MEM-stage load/store request.
REQ-006 i_arb_core_we, i_arb_core_bytectrl  in  1, 3  core write enable and byte control.
REQ-007 i_arb_core_a, i_arb_core_wd  in  XLEN each  core address and write data.
REQ-008 o_arb_core_stall  out  1  freeze IF..MEM; high when core_req is high and core is not granted.
REQ-009 o_arb_core_rvalid, o_arb_core_rd  out  1, XLEN  core read response.
REQ-010 i_arb_ext_req, i_arb_ext_we, i_arb_ext_bytectrl, i_arb_ext_a, i_arb_ext_wd  in  1, 1, 3, XLEN, XLEN  external (loader/debug) request.
REQ-011 o_arb_ext_gnt, o_arb_ext_rvalid, o_arb_ext_rd  out  1, 1, XLEN  external grant and read response.
REQ-012 o_arb_dmem_a, o_arb_dmem_we, o_arb_dmem_wd, o_arb_dmem_bytectrl  out  XLEN, 1, XLEN, 3  shared memory port; i_arb_dmem_rd  in  XLEN  read data, valid one cycle after address.

Function
REQ-013 Grant: combinational, at most one of core/ext per cycle; granted requester's a/we/wd/bytectrl drive the dmem port in the same cycle.
REQ-014 No grant: dmem_we=0, dmem_a=0, dmem_wd=0, dmem_bytectrl=0.
REQ-015 Default policy: core wins when both request; ext granted when core_req=0.
REQ-016 Starvation counter (4 bits): increments each cycle ext_req=1 and ext not granted; clears on ext grant or ext_req=0; at count==STARVE_LIMIT ext is granted that cycle and core stalled.
REQ-017 Ext handshake: transfer occurs in cycle ext_req & ext_gnt; ext holds request fields stable until granted; dropping ext_req before grant is legal, no transfer, counter clears.
REQ-018 Response FSM, registered each cycle: RSP_NONE, RSP_CORE (core granted, we=0), RSP_EXT (ext granted, we=0); writes and idle go to RSP_NONE.
REQ-019 In RSP_CORE: o_arb_core_rvalid=1, o_arb_core_rd=i_arb_dmem_rd; in RSP_EXT: likewise for ext; otherwise rvalid=0, rd=0.
REQ-020 Read latency: 1 cycle grant-to-rvalid; back-to-back grants pipeline, one response per cycle, alternating owners allowed.
REQ-021 Stall is combinational and never asserted when core_req=0.

Reset
REQ-022 While i_arb_rst=1 at a clock edge: FSM=RSP_NONE, counter=0, round-robin last-owner=EXT; next cycle all rvalid=0 and rd=0.
REQ-023 Reset mid-operation drops any in-flight read response; no rvalid after reset for pre-reset grants.
REQ-024 Grant/stall logic stays combinational during reset; dmem_we forced 0 while i_arb_rst=1.

Configuration
REQ-025 Macro DMEM_ARB_RR_EN defined: when both request, grant goes to requester not granted last (1-bit last-owner register updated on every grant); starvation counter removed.
REQ-026 Macro undefined: fixed core priority with STARVE_LIMIT forced grant (REQ-015, REQ-016); no last-owner register.

Verification
REQ-027 Core load only, core_a=0x100, dmem_rd=0xDEADBEEF next cycle -> stall=0, core_rvalid=1 with 0xDEADBEEF at cycle+1, ext_rvalid=0.
REQ-028 Fixed mode, STARVE_LIMIT=3, core_req and ext_req held high 5 cycles -> ext_gnt=0 cycles 0-2, ext_gnt=1 and core_stall=1 cycle 3, core granted cycle 4.
REQ-029 RR mode, both requesting continuously from reset -> grants core, ext, core, ext; stall=1 on ext cycles only.
REQ-030 Core store we=1 a=0x200 wd=0x12345678 bytectrl=3'b010 while ext idle -> dmem port matches same cycle, no rvalid next cycle.
REQ-031 Ext load granted cycle N, i_arb_rst=1 at edge N+1 -> ext_rvalid=0 at N+1, FSM=RSP_NONE, counter=0.
REQ-032 Ext read granted cycle N, core read granted N+1 -> ext_rvalid at N+1, core_rvalid at N+2, each with the matching dmem_rd.

Source files
------------

// File: rtl/rv_dmem_arbiter_if.sv
// Bundle between the pipeline/external requesters and the data-memory arbiter.
// The master modport is the requester and memory side; the slave modport is the arbiter.
interface rv_dmem_arbiter_if #(
    parameter int unsigned XLEN = 32
);
    logic            i_arb_core_req;
    logic            i_arb_core_we;
    logic [2:0]      i_arb_core_bytectrl;
    logic [XLEN-1:0] i_arb_core_a;
    logic [XLEN-1:0] i_arb_core_wd;
    logic            o_arb_core_stall;
    logic            o_arb_core_rvalid;
    logic [XLEN-1:0] o_arb_core_rd;

    logic            i_arb_ext_req;
    logic            i_arb_ext_we;
    logic [2:0]      i_arb_ext_bytectrl;
    logic [XLEN-1:0] i_arb_ext_a;
    logic [XLEN-1:0] i_arb_ext_wd;
    logic            o_arb_ext_gnt;
    logic            o_arb_ext_rvalid;
    logic [XLEN-1:0] o_arb_ext_rd;

    logic [XLEN-1:0] o_arb_dmem_a;
    logic            o_arb_dmem_we;
    logic [XLEN-1:0] o_arb_dmem_wd;
    logic [2:0]      o_arb_dmem_bytectrl;
    logic [XLEN-1:0] i_arb_dmem_rd;

    modport master (
        output i_arb_core_req, i_arb_core_we, i_arb_core_bytectrl, i_arb_core_a, i_arb_core_wd,
        input  o_arb_core_stall, o_arb_core_rvalid, o_arb_core_rd,
        output i_arb_ext_req, i_arb_ext_we, i_arb_ext_bytectrl, i_arb_ext_a, i_arb_ext_wd,
        input  o_arb_ext_gnt, o_arb_ext_rvalid, o_arb_ext_rd,
        input  o_arb_dmem_a, o_arb_dmem_we, o_arb_dmem_wd, o_arb_dmem_bytectrl,
        output i_arb_dmem_rd
    );

    modport slave (
        input  i_arb_core_req, i_arb_core_we, i_arb_core_bytectrl, i_arb_core_a, i_arb_core_wd,
        output o_arb_core_stall, o_arb_core_rvalid, o_arb_core_rd,
        input  i_arb_ext_req, i_arb_ext_we, i_arb_ext_bytectrl, i_arb_ext_a, i_arb_ext_wd,
        output o_arb_ext_gnt, o_arb_ext_rvalid, o_arb_ext_rd,
        output o_arb_dmem_a, o_arb_dmem_we, o_arb_dmem_wd, o_arb_dmem_bytectrl,
        input  i_arb_dmem_rd
    );
endinterface

// File: rtl/rv_dmem_arbiter.sv
// Data-memory arbiter between the core MEM stage and an external loader/debug port.
// Define DMEM_ARB_RR_EN for round-robin arbitration; otherwise core priority with starvation guard.
module rv_dmem_arbiter #(
    parameter int unsigned XLEN         = 32,
    parameter int unsigned STARVE_LIMIT = 3
) (
    input logic              i_arb_clk,
    input logic              i_arb_rst,
    rv_dmem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {RspNone, RspCore, RspExt} rsp_e;

    rsp_e rsp_q;
    logic core_gnt;
    logic ext_gnt;

`ifdef DMEM_ARB_RR_EN
    logic last_ext_q;

    // On contention, serve whoever did not own the port last.
    always_comb begin
        ext_gnt = bus.i_arb_ext_req & (~bus.i_arb_core_req | ~last_ext_q);
    end

    always_ff @(posedge i_arb_clk) begin
        if (i_arb_rst) begin
            last_ext_q <= 1'b1;
        end else if (core_gnt) begin
            last_ext_q <= 1'b0;
        end else if (ext_gnt) begin
            last_ext_q <= 1'b1;
        end
    end
`else
    logic [3:0] starve_cnt_q;
    logic       starve_hit;

    assign starve_hit = (starve_cnt_q == 4'(STARVE_LIMIT));

    always_comb begin
        ext_gnt = bus.i_arb_ext_req & (~bus.i_arb_core_req | starve_hit);
    end

    always_ff @(posedge i_arb_clk) begin
        if (i_arb_rst || !bus.i_arb_ext_req || ext_gnt) begin
            starve_cnt_q <= 4'd0;
        end else begin
            starve_cnt_q <= starve_cnt_q + 4'd1;
        end
    end
`endif

    assign core_gnt         = bus.i_arb_core_req & ~ext_gnt;
    assign bus.o_arb_ext_gnt    = ext_gnt;
    assign bus.o_arb_core_stall = bus.i_arb_core_req & ~core_gnt;

    always_comb begin
        bus.o_arb_dmem_a        = '0;
        bus.o_arb_dmem_we       = 1'b0;
        bus.o_arb_dmem_wd       = '0;
        bus.o_arb_dmem_bytectrl = 3'd0;
        if (core_gnt) begin
            bus.o_arb_dmem_a        = bus.i_arb_core_a;
            bus.o_arb_dmem_we       = bus.i_arb_core_we & ~i_arb_rst;
            bus.o_arb_dmem_wd       = bus.i_arb_core_wd;
            bus.o_arb_dmem_bytectrl = bus.i_arb_core_bytectrl;
        end else if (ext_gnt) begin
            bus.o_arb_dmem_a        = bus.i_arb_ext_a;
            bus.o_arb_dmem_we       = bus.i_arb_ext_we & ~i_arb_rst;
            bus.o_arb_dmem_wd       = bus.i_arb_ext_wd;
            bus.o_arb_dmem_bytectrl = bus.i_arb_ext_bytectrl;
        end
    end

    // Remembers who owns the read data arriving from memory next cycle.
    always_ff @(posedge i_arb_clk) begin
        if (i_arb_rst) begin
            rsp_q <= RspNone;
        end else if (core_gnt && !bus.i_arb_core_we) begin
            rsp_q <= RspCore;
        end else if (ext_gnt && !bus.i_arb_ext_we) begin
            rsp_q <= RspExt;
        end else begin
            rsp_q <= RspNone;
        end
    end

    assign bus.o_arb_core_rvalid = (rsp_q == RspCore);
    assign bus.o_arb_ext_rvalid  = (rsp_q == RspExt);
    assign bus.o_arb_core_rd     = (rsp_q == RspCore) ? bus.i_arb_dmem_rd : '0;
    assign bus.o_arb_ext_rd      = (rsp_q == RspExt) ? bus.i_arb_dmem_rd : '0;
endmodule
